// File: rtl/io_port_responder.sv
// io_port_responder: port-bus responder for LEDs, 7-seg, timer, PEND/MASK and INTR; IO_BUTTON_DEBOUNCE_EN adds button debounce.
// Latency: writes visible next cycle, IN_PORT combinational, board inputs 2 cycles, INTR one cycle after the event.
// Backpressure: none; every IO_STRB write is accepted in its own cycle.
module io_port_responder #(
   parameter int PRESCALE        = 50000,
   parameter int INTR_PULSE      = 2,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] PORT_ID,
   input  logic [7:0] OUT_PORT,
   input  logic       IO_STRB,
   output logic [7:0] IN_PORT,
   input  logic [7:0] SWITCHES,
   input  logic [3:0] BUTTONS,
   output logic [7:0] LEDS,
   output logic [7:0] SSEG_VAL,
   output logic       INTR
);

   localparam logic [7:0] P_SWITCHES = 8'h20;
   localparam logic [7:0] P_BUTTONS  = 8'h24;
   localparam logic [7:0] P_LEDS     = 8'h40;
   localparam logic [7:0] P_SSEG     = 8'h81;
   localparam logic [7:0] P_CTRL     = 8'hB0;
   localparam logic [7:0] P_LOAD     = 8'hB1;
   localparam logic [7:0] P_CNT      = 8'hB2;
   localparam logic [7:0] P_PEND     = 8'hB3;
   localparam logic [7:0] P_MASK     = 8'hB4;

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int PC_W = $clog2(INTR_PULSE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(INTR_PULSE - 1);

   typedef enum logic {S_IDLE, S_PULSE} state_t;

   logic [7:0]      sw_meta, sw_sync;
   logic [3:0]      btn_meta, btn_sync, btn_lvl, btn_prev;
   logic [7:0]      leds_q, sseg_q, load_q, cnt_q;
   logic            en_q, auto_q;
   logic [PS_W-1:0] ps_q;
   logic [1:0]      pend_q, mask_q;
   state_t          state_q, state_d;
   logic [PC_W-1:0] pulse_cnt_q, pulse_cnt_d;

   logic            wr_leds, wr_sseg, wr_ctrl, wr_load, wr_pend, wr_mask;
   logic            tick, expire, start;
   logic [1:0]      pend_set, pend_clr, pend_new;
   logic            unmask_hit, trigger;

   assign wr_leds = IO_STRB && (PORT_ID == P_LEDS);
   assign wr_sseg = IO_STRB && (PORT_ID == P_SSEG);
   assign wr_ctrl = IO_STRB && (PORT_ID == P_CTRL);
   assign wr_load = IO_STRB && (PORT_ID == P_LOAD);
   assign wr_pend = IO_STRB && (PORT_ID == P_PEND);
   assign wr_mask = IO_STRB && (PORT_ID == P_MASK);

   // Two-flop synchronisers; btn_prev follows whichever level feeds edge detection
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
         btn_prev <= '0;
      end else begin
         sw_meta  <= SWITCHES;
         sw_sync  <= sw_meta;
         btn_meta <= BUTTONS;
         btn_sync <= btn_meta;
         btn_prev <= btn_lvl;
      end
   end

`ifdef IO_BUTTON_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]      btn_deb;
   logic [DB_W-1:0] db_cnt [4];

   // A counter runs only while the synced bit disagrees with the debounced level
   always_ff @(posedge CLK) begin
      if (RESET) begin
         btn_deb <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (btn_sync[i] != btn_deb[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  btn_deb[i] <= btn_sync[i];
                  db_cnt[i]  <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign btn_lvl = btn_deb;
`else
   assign btn_lvl = btn_sync;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         leds_q <= '0;
         sseg_q <= '0;
         load_q <= '0;
      end else begin
         if (wr_leds) leds_q <= OUT_PORT;
         if (wr_sseg) sseg_q <= OUT_PORT;
         if (wr_load) load_q <= OUT_PORT;
      end
   end

   assign tick   = en_q && (ps_q == PS_LAST);
   assign expire = tick && (cnt_q == 8'd0);
   assign start  = wr_ctrl && OUT_PORT[0] && !en_q;

   // A CTRL write owns EN/AUTO that cycle; otherwise a one-shot expiry drops EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         en_q   <= 1'b0;
         auto_q <= 1'b0;
         cnt_q  <= '0;
         ps_q   <= '0;
      end else begin
         if (wr_ctrl) begin
            en_q   <= OUT_PORT[0];
            auto_q <= OUT_PORT[1];
         end else if (expire && !auto_q) begin
            en_q <= 1'b0;
         end

         if (start) begin
            cnt_q <= load_q;
            ps_q  <= '0;
         end else if (en_q) begin
            ps_q <= tick ? '0 : ps_q + 1'b1;
            if (tick) begin
               if (cnt_q != 8'd0) cnt_q <= cnt_q - 1'b1;
               else if (auto_q)   cnt_q <= load_q;
            end
         end
      end
   end

   assign pend_set   = {|(btn_lvl & ~btn_prev), expire};
   assign pend_clr   = wr_pend ? OUT_PORT[1:0] : 2'b00;
   assign pend_new   = pend_set & ~pend_q;
   assign unmask_hit = wr_mask && |(OUT_PORT[1:0] & ~mask_q & pend_q);
   assign trigger    = |(pend_new & mask_q) || unmask_hit;

   // Set is ORed in after the clear so a same-cycle event wins over W1C
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pend_q <= '0;
         mask_q <= '0;
      end else begin
         pend_q <= (pend_q & ~pend_clr) | pend_set;
         if (wr_mask) mask_q <= OUT_PORT[1:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         pulse_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pulse_cnt_q <= pulse_cnt_d;
      end
   end

   // Triggers are only looked at in IDLE, so events during a pulse never stretch it
   always_comb begin
      state_d     = state_q;
      pulse_cnt_d = pulse_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d     = S_PULSE;
               pulse_cnt_d = '0;
            end
         end
         S_PULSE: begin
            if (pulse_cnt_q == PC_LAST) state_d = S_IDLE;
            else                        pulse_cnt_d = pulse_cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      IN_PORT = 8'h00;
      case (PORT_ID)
         P_SWITCHES: IN_PORT = sw_sync;
         P_BUTTONS:  IN_PORT = {4'b0000, btn_lvl};
         P_LEDS:     IN_PORT = leds_q;
         P_SSEG:     IN_PORT = sseg_q;
         P_CTRL:     IN_PORT = {6'b000000, auto_q, en_q};
         P_LOAD:     IN_PORT = load_q;
         P_CNT:      IN_PORT = cnt_q;
         P_PEND:     IN_PORT = {6'b000000, pend_q};
         P_MASK:     IN_PORT = {6'b000000, mask_q};
         default:    IN_PORT = 8'h00;
      endcase
   end

   assign LEDS     = leds_q;
   assign SSEG_VAL = sseg_q;
   assign INTR     = (state_q == S_PULSE);

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: directed literal checks plus randomized traffic against a behavioural model.
module tb_io_port_responder;

   localparam int PS = 4;
   localparam int IP = 2;
   localparam int DB = 8;

   logic       CLK = 1'b0;
   logic       RESET, IO_STRB, INTR;
   logic [7:0] PORT_ID, OUT_PORT, SWITCHES, IN_PORT, LEDS, SSEG_VAL;
   logic [3:0] BUTTONS;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 CLK = ~CLK;

   io_port_responder #(.PRESCALE(PS), .INTR_PULSE(IP), .DEBOUNCE_CYCLES(DB)) u_dut (
      .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
      .IN_PORT(IN_PORT), .SWITCHES(SWITCHES), .BUTTONS(BUTTONS), .LEDS(LEDS),
      .SSEG_VAL(SSEG_VAL), .INTR(INTR)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_sw1, m_sw2, m_leds, m_sseg, m_load, m_cnt;
   logic [3:0] m_b1, m_b2, m_bprev, m_lvl;
   logic       m_en, m_auto, m_tick, m_expire, m_fire, m_ctrl_wr;
   logic [1:0] m_pend, m_mask, m_set, m_clr;
   int         m_ps, m_left;
`ifdef IO_BUTTON_DEBOUNCE_EN
   logic [3:0] m_deb;
   int         m_dc [4];
`endif

   function automatic logic [7:0] m_read(input logic [7:0] pid);
      case (pid)
         8'h20:   return m_sw2;
         8'h24:   return {4'b0000, m_lvl};
         8'h40:   return m_leds;
         8'h81:   return m_sseg;
         8'hB0:   return {6'b000000, m_auto, m_en};
         8'hB1:   return m_load;
         8'hB2:   return m_cnt;
         8'hB3:   return {6'b000000, m_pend};
         8'hB4:   return {6'b000000, m_mask};
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
`ifdef IO_BUTTON_DEBOUNCE_EN
      m_lvl = m_deb;
`else
      m_lvl = m_b2;
`endif
      m_ctrl_wr = IO_STRB && (PORT_ID == 8'hB0);
      m_tick    = m_en && (m_ps == PS - 1);
      m_expire  = m_tick && (m_cnt == 8'd0);
      m_set     = {|(m_lvl & ~m_bprev), m_expire};
      m_clr     = (IO_STRB && PORT_ID == 8'hB3) ? OUT_PORT[1:0] : 2'b00;
      m_fire    = (m_left == 0) &&
                  (|(m_set & ~m_pend & m_mask) ||
                   (IO_STRB && PORT_ID == 8'hB4 && |(OUT_PORT[1:0] & ~m_mask & m_pend)));
   end

   always @(posedge CLK) begin
      if (RESET) begin
         m_sw1 <= 0; m_sw2 <= 0; m_b1 <= 0; m_b2 <= 0; m_bprev <= 0;
         m_leds <= 0; m_sseg <= 0; m_load <= 0; m_cnt <= 0; m_ps <= 0;
         m_en <= 0; m_auto <= 0; m_pend <= 0; m_mask <= 0; m_left <= 0;
`ifdef IO_BUTTON_DEBOUNCE_EN
         m_deb <= 0;
         for (int i = 0; i < 4; i++) m_dc[i] <= 0;
`endif
      end else begin
         m_sw1 <= SWITCHES; m_sw2 <= m_sw1;
         m_b1 <= BUTTONS;   m_b2 <= m_b1;
         m_bprev <= m_lvl;
`ifdef IO_BUTTON_DEBOUNCE_EN
         for (int i = 0; i < 4; i++) begin
            if (m_b2[i] != m_deb[i]) begin
               if (m_dc[i] + 1 == DB) begin m_deb[i] <= m_b2[i]; m_dc[i] <= 0; end
               else m_dc[i] <= m_dc[i] + 1;
            end else m_dc[i] <= 0;
         end
`endif
         if (IO_STRB && PORT_ID == 8'h40) m_leds <= OUT_PORT;
         if (IO_STRB && PORT_ID == 8'h81) m_sseg <= OUT_PORT;
         if (IO_STRB && PORT_ID == 8'hB1) m_load <= OUT_PORT;
         if (IO_STRB && PORT_ID == 8'hB4) m_mask <= OUT_PORT[1:0];
         m_pend <= (m_pend & ~m_clr) | m_set;
         m_left <= m_fire ? IP : ((m_left > 0) ? m_left - 1 : 0);
         if (m_ctrl_wr && OUT_PORT[0] && !m_en) begin
            m_cnt <= m_load;
            m_ps  <= 0;
         end else if (m_en) begin
            m_ps <= m_tick ? 0 : m_ps + 1;
            if (m_tick) m_cnt <= (m_cnt != 0) ? m_cnt - 8'd1 : (m_auto ? m_load : m_cnt);
         end
         if (m_ctrl_wr) begin
            m_en   <= OUT_PORT[0];
            m_auto <= OUT_PORT[1];
         end else if (m_expire && !m_auto) m_en <= 1'b0;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("in_port", IN_PORT, m_read(PORT_ID));
         chk("leds", LEDS, m_leds);
         chk("sseg_val", SSEG_VAL, m_sseg);
         chk("intr", INTR, m_left > 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      PORT_ID = p; OUT_PORT = d; IO_STRB = 1'b1;
      step();
      IO_STRB = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [7:0] p, input logic [7:0] exp);
      PORT_ID = p;
      #1;
      chk(name, IN_PORT, exp);
   endtask

   logic [7:0]  ports [10] = '{8'h20, 8'h24, 8'h40, 8'h81, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h55};
   logic [31:0] rv;

   initial begin
      RESET = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
      SWITCHES = 8'h00; BUTTONS = 4'h0;
      repeat (3) @(posedge CLK);
      #1;
      RESET  = 1'b0;
      chk_en = 1'b1;

      for (int i = 0; i < 10; i++) rd_chk("reset_read", ports[i], 8'h00);
      chk("reset_leds", LEDS, 8'h00);
      chk("reset_sseg", SSEG_VAL, 8'h00);
      chk("reset_intr", INTR, 1'b0);

      wr(8'h40, 8'hA5);
      chk("leds_write", LEDS, 8'hA5);
      PORT_ID = 8'h40; OUT_PORT = 8'h5A; IO_STRB = 1'b0;
      step();
      chk("leds_no_strobe", LEDS, 8'hA5);

      // Auto-reload timer: LOAD=3, PRESCALE=4 -> one event every 16 cycles
      wr(8'hB4, 8'h01);
      wr(8'hB1, 8'h03);
      wr(8'hB0, 8'h03);
      for (int k = 0; k < 4; k++) begin
         rd_chk("cnt_seq", 8'hB2, 8'(3 - k));
         chk("intr_quiet", INTR, 1'b0);
         repeat (4) step();
      end
      chk("intr_first_hi0", INTR, 1'b1);
      rd_chk("pend_timer", 8'hB3, 8'h01);
      step(); chk("intr_first_hi1", INTR, 1'b1);
      step(); chk("intr_first_lo", INTR, 1'b0);
      wr(8'hB3, 8'h01);
      repeat (13) step();
      chk("intr_second_hi0", INTR, 1'b1);
      step(); chk("intr_second_hi1", INTR, 1'b1);
      step(); chk("intr_second_lo", INTR, 1'b0);

      // One-shot with LOAD=0
      wr(8'hB0, 8'h00);
      wr(8'hB1, 8'h00);
      wr(8'hB3, 8'h03);
      wr(8'hB0, 8'h01);
      repeat (3) step();
      chk("oneshot_pre", INTR, 1'b0);
      step();
      chk("oneshot_intr", INTR, 1'b1);
      rd_chk("oneshot_ctrl", 8'hB0, 8'h00);
      rd_chk("oneshot_pend", 8'hB3, 8'h01);
      repeat (8) step();
      rd_chk("oneshot_cnt_frozen", 8'hB2, 8'h00);
      chk("oneshot_single", INTR, 1'b0);

      // Expiry coinciding with W1C; button event lands during the pulse
      wr(8'hB3, 8'h01);
      wr(8'hB4, 8'h03);
      wr(8'hB0, 8'h01);
      step();
      step();
`ifndef IO_BUTTON_DEBOUNCE_EN
      BUTTONS = 4'h4;
`endif
      step();
      wr(8'hB3, 8'h01);
      rd_chk("set_beats_w1c", 8'hB3, 8'h01);
      chk("race_intr_hi0", INTR, 1'b1);
`ifndef IO_BUTTON_DEBOUNCE_EN
      rd_chk("buttons_sync", 8'h24, 8'h04);
      step();
      rd_chk("button_pend_3cyc", 8'hB3, 8'h03);
      chk("race_intr_hi1", INTR, 1'b1);
      step(); chk("pulse_not_extended", INTR, 1'b0);
      step(); chk("pulse_not_retriggered", INTR, 1'b0);
      wr(8'hB4, 8'h00);
      wr(8'hB4, 8'h02);
`else
      step(); chk("race_intr_hi1", INTR, 1'b1);
      step(); chk("race_intr_lo", INTR, 1'b0);
      wr(8'hB4, 8'h00);
      wr(8'hB4, 8'h01);
`endif
      chk("unmask_hi0", INTR, 1'b1);
      step(); chk("unmask_hi1", INTR, 1'b1);
      step(); chk("unmask_lo", INTR, 1'b0);

`ifdef IO_BUTTON_DEBOUNCE_EN
      wr(8'hB3, 8'h03);
      wr(8'hB4, 8'h02);
      BUTTONS = 4'h1;
      repeat (5) step();
      BUTTONS = 4'h0;
      repeat (20) begin step(); chk("glitch_no_intr", INTR, 1'b0); end
      rd_chk("glitch_no_pend", 8'hB3, 8'h00);
      BUTTONS = 4'h2;
      repeat (20) step();
      rd_chk("press_pend", 8'hB3, 8'h02);
      rd_chk("press_level", 8'h24, 8'h02);
`endif
      BUTTONS = 4'h0;
      repeat (20) step();

      // Randomized traffic, checked every cycle by the compare process
      for (int c = 0; c < 6000; c++) begin
         rv = $urandom();
         IO_STRB = (rv[6:0] < 7'd40);
         PORT_ID = (rv[10:7] < 4'd10) ? ports[rv[10:7]] : rv[31:24];
         OUT_PORT = rv[23:16];
         if (PORT_ID == 8'hB1) OUT_PORT = 8'($urandom_range(0, 4));
         if (PORT_ID == 8'hB0 && rv[11]) OUT_PORT[0] = 1'b1;
         if (rv[14:12] == 3'd0) SWITCHES = 8'($urandom());
         if (rv[20:15] < 6'd3) BUTTONS[rv[22:21]] = ~BUTTONS[rv[22:21]];
         RESET = ($urandom_range(0, 499) == 0);
         step();
         RESET = 1'b0;
      end

      IO_STRB = 1'b0;
      repeat (4) step();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Memory-mapped I/O responder that sits on the CPU port bus (PORT_ID, OUT_PORT, IO_STRB, IN_PORT) opposite the microcontroller core.
- Decodes output writes into board latches (LEDs, seven-segment value) and timer/interrupt registers.
- Drives the IN_PORT read mux from switches, buttons and internal registers.
- Generates the INTR pulse fed to the core from a programmable down-counting timer and button edges.

Parameters:
- PRESCALE, 50000, CLK cycles per timer tick (>=1)
- INTR_PULSE, 2, INTR high time in CLK cycles (>=2, covers the core's two-state fetch/exec)
- DEBOUNCE_CYCLES, 500000, stable-input cycles required per button (used only with the optional feature)

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- PORT_ID  in  8  port address from the core
- OUT_PORT  in  8  write data from the core
- IO_STRB  in  1  write strobe; one-cycle-high qualifies PORT_ID/OUT_PORT
- IN_PORT  out  8  read data to the core
- SWITCHES  in  8  asynchronous board switches
- BUTTONS  in  4  asynchronous board buttons
- LEDS  out  8  LED latch
- SSEG_VAL  out  8  seven-segment value latch
- INTR  out  1  interrupt request to the core

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high; every register clears to 0 on the reset edge. This includes LEDS, SSEG_VAL, CTRL, LOAD, CNT, prescaler, PEND, MASK, sync flops and the FSM (IDLE, INTR=0). Reset mid-pulse or mid-count aborts immediately.
- Port map (R = read via IN_PORT, W = write on IO_STRB):
  - 0x20 R: SWITCHES, synced.
  - 0x24 R: {4'b0, BUTTONS synced}.
  - 0x40 R/W: LEDS.
  - 0x81 R/W: SSEG_VAL.
  - 0xB0 R/W: CTRL. Bit0 EN, bit1 AUTO; bits 7:2 are written-ignored and read 0.
  - 0xB1 R/W: LOAD.
  - 0xB2 R: CNT.
  - 0xB3 R/W1C: PEND. Bit0 timer, bit1 button; upper bits read 0.
  - 0xB4 R/W: MASK[1:0].
  - Unmapped reads return 0x00. Unmapped writes are ignored. Writes to read-only ports are ignored.
- Writes: take effect at the CLK edge where IO_STRB=1 and are visible on outputs and IN_PORT the next cycle. Writes with IO_STRB=0 have no effect.
- IN_PORT: combinational decode of PORT_ID over registered/synced values; no strobe required.
- Input sync: SWITCHES and BUTTONS pass through 2 flops, giving 2-cycle latency to IN_PORT.
- Timer:
  - Prescaler counts 0..PRESCALE-1; tick fires at wrap while EN=1.
  - Writing CTRL with EN 0->1 loads CNT<=LOAD and clears the prescaler.
  - On tick with CNT!=0: CNT decrements.
  - On tick with CNT==0: PEND[0] sets. If AUTO=1, CNT<=LOAD; else EN clears.
  - Writing EN=0 freezes CNT and the prescaler.
  - A LOAD write while running affects only the next reload.
  - LOAD=0 with AUTO=1 gives an event every tick.
- Button events: a rising edge on any synced button bit sets PEND[1].
- Pending clear: writing 1 to a PEND bit clears it. If a set event and a W1C hit the same bit in the same cycle, set wins.
- INTR FSM: states IDLE and PULSE, with a pulse counter.
  - IDLE->PULSE in the cycle after any PEND bit newly sets while its MASK bit is 1. INTR=1 for exactly INTR_PULSE cycles, then IDLE.
  - Events arriving during PULSE latch into PEND but neither extend nor retrigger the pulse.
  - In IDLE, a MASK write that unmasks an already-pending bit triggers a pulse.
  - MASK=0 blocks INTR only; PEND still sets.

Optional Feature:
- Macro: IO_BUTTON_DEBOUNCE_EN.
- Defined: each synced button feeds a per-bit counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a differing synced value. Port 0x24 and edge detection use the debounced level. Reset clears the debounced levels and counters.
- Undefined: no debounce logic; 0x24 and edge detection use the 2-flop synced value directly.

Test Plan:
- Reset, then read ports 0x20/0x24/0x40/0x81/0xB0-0xB4 and unmapped 0x55 -> all read 0x00; LEDS=0, SSEG_VAL=0, INTR=0.
- IO_STRB pulse with PORT_ID=0x40, OUT_PORT=0xA5 -> LEDS=0xA5 next cycle. Same write with IO_STRB=0 -> LEDS unchanged.
- PRESCALE=4, LOAD=3, MASK=1, CTRL=0x03 -> PEND[0] sets every 16 cycles and INTR is high exactly 2 cycles each time. Read 0xB2 -> 3,2,1,0 sequence.
- CTRL=0x01 (one-shot), LOAD=0 -> one event after 4 cycles, then CTRL reads 0x00 and CNT is frozen.
- Same-cycle timer expiry and W1C write of 0x01 to 0xB3 -> PEND[0]=1. Event during an active pulse -> pulse stays 2 cycles. MASK=0 then MASK=1 with PEND[1] set -> one INTR pulse.
- BUTTONS 0->0x4 (macro off) -> PEND[1]=1 three cycles later. With macro on and DEBOUNCE_CYCLES=8, a 5-cycle glitch -> no event; a stable 8+ cycle press -> one event.
